// File: rtl/cache_refill_axi_master_if.sv
// AXI4 read-only channel bundle (AR + R) between a refill master and its memory port.
interface cache_refill_axi_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]            arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cache_refill_axi_master.sv
// Cache line refill engine: one aligned AXI4 INCR read burst per miss, beats forwarded to the fill port.
module cache_refill_axi_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          busy,
  output logic                          fill_valid,
  output logic [DATA_WIDTH-1:0]         fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_index,
  output logic                          fill_last,
  output logic                          fill_err,
  cache_refill_axi_master_if.master     m_axi
);

  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned LINE_BYTES = LINE_WORDS * BEAT_BYTES;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [3:0]            ID        = 4'(AXI_ID);
  localparam logic [7:0]            BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [2:0]            BEAT_SIZE = 3'($clog2(BEAT_BYTES));

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] beat_cnt;
  logic             err_q;
  logic             req_hs_c, ar_hs_c, r_hs_c, last_beat_c, beat_err_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and handshake decode; arvalid/rready are high exactly in ADDR/DATA
  always_comb begin
    state_n     = state;
    req_hs_c    = 1'b0;
    ar_hs_c     = 1'b0;
    r_hs_c      = 1'b0;
    last_beat_c = (beat_cnt == LAST_IDX);
    beat_err_c  = (m_axi.rresp != 2'b00) || (m_axi.rid != ID) || (m_axi.rlast != last_beat_c);
    case (state)
      IDLE: if (req_valid && req_ready) begin
        req_hs_c = 1'b1;
        state_n  = ADDR;
      end
      ADDR: if (m_axi.arready) begin
        ar_hs_c = 1'b1;
        state_n = DATA;
      end
      DATA: if (m_axi.rvalid) begin
        r_hs_c = 1'b1;
        if (last_beat_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered AR channel, fill port, beat counter and sticky line error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      fill_valid    <= 1'b0;
      fill_data     <= '0;
      fill_index    <= '0;
      fill_last     <= 1'b0;
      fill_err      <= 1'b0;
      m_axi.arid    <= '0;
      m_axi.araddr  <= '0;
      m_axi.arlen   <= '0;
      m_axi.arsize  <= '0;
      m_axi.arburst <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
      beat_cnt      <= '0;
      err_q         <= 1'b0;
    end else begin
      req_ready    <= (state_n == IDLE);
      busy         <= (state_n != IDLE) || r_hs_c;
      m_axi.rready <= (state_n == DATA);
      fill_valid   <= r_hs_c;
      fill_last    <= r_hs_c && last_beat_c;
      fill_err     <= r_hs_c && last_beat_c && (err_q || beat_err_c);
      if (req_hs_c) begin
        m_axi.arid    <= ID;
        m_axi.araddr  <= req_addr & LINE_MASK;
        m_axi.arlen   <= BURST_LEN;
        m_axi.arsize  <= BEAT_SIZE;
        m_axi.arburst <= 2'b01;
        m_axi.arvalid <= 1'b1;
        beat_cnt      <= '0;
        err_q         <= 1'b0;
      end
      if (ar_hs_c) m_axi.arvalid <= 1'b0;
      if (r_hs_c) begin
        fill_data  <= m_axi.rdata;
        fill_index <= beat_cnt;
        beat_cnt   <= beat_cnt + IDX_W'(1);
        err_q      <= err_q || beat_err_c;
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_axi_master.sv
// Bench for cache_refill_axi_master: configurable AXI read slave, fill monitor, line-level reference model.
module tb_cache_refill_axi_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, busy;
  logic [AW-1:0] req_addr;
  logic          fill_valid, fill_last, fill_err;
  logic [DW-1:0] fill_data;
  logic [1:0]    fill_index;

  always #5 clk = ~clk;

  cache_refill_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  cache_refill_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data), .fill_index(fill_index),
    .fill_last(fill_last), .fill_err(fill_err), .m_axi(axi)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory, one word per 4 bytes
  logic [31:0] mem [0:1023];

  // Slave behaviour knobs
  int ar_delay;
  int gap_tab [LW];
  int err_beat;
  int rlast_beat;
  bit bad_rid;

  // Slave internals
  bit          s_active, s_ar_hs, s_r_hs, s_arv;
  logic [31:0] s_addr, s_ar_addr;
  int          s_beat, s_gap, s_arcnt;

  // Monitor results
  typedef struct {logic [31:0] data; int idx; bit last; bit err;} fill_t;
  fill_t       fills [$];
  int          ar_count, ar_unstable;
  logic [48:0] ar_seen, p_ar;
  bit          p_wait;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int ard, input int g0, input int g1, input int g2, input int g3,
                     input int eb, input int rlb, input bit brid);
    ar_delay = ard; gap_tab[0] = g0; gap_tab[1] = g1; gap_tab[2] = g2; gap_tab[3] = g3;
    err_beat = eb; rlast_beat = rlb; bad_rid = brid;
  endtask

  function automatic bit model_err();
    return (err_beat >= 0 && err_beat < int'(LW)) || bad_rid ||
           (rlast_beat >= 0 && rlast_beat != int'(LW) - 1);
  endfunction

  // AXI read slave: inputs updated 1ns after each rising edge from handshakes sampled at the falling edge
  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rid = '0;
    s_active = 0; s_arcnt = 0; s_beat = 0; s_gap = 0; s_addr = '0;
    forever begin
      @(negedge clk);
      s_ar_hs = axi.arvalid && axi.arready;
      s_r_hs  = axi.rvalid && axi.rready;
      s_arv   = axi.arvalid;
      s_ar_addr = axi.araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_active = 0; s_arcnt = 0; axi.arready = 1'b0; axi.rvalid = 1'b0;
      end else begin
        if (s_ar_hs) begin
          s_active = 1; s_addr = s_ar_addr; s_beat = 0; s_gap = gap_tab[0]; s_arcnt = 0;
        end else if (s_arv) begin
          s_arcnt++;
        end
        if (s_r_hs) begin
          s_beat++;
          if (s_beat >= int'(LW)) s_active = 0;
          else s_gap = gap_tab[s_beat];
        end
        axi.arready = (s_arcnt >= ar_delay);
        if (s_active && s_gap == 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = mem[(s_addr >> 2) + 32'(s_beat)];
          axi.rresp  = (s_beat == err_beat) ? 2'b10 : 2'b00;
          axi.rlast  = (rlast_beat >= 0) ? (s_beat == rlast_beat) : (s_beat == int'(LW) - 1);
          axi.rid    = bad_rid ? 4'd5 : 4'd0;
        end else begin
          axi.rvalid = 1'b0;
          if (s_active) s_gap--;
        end
      end
    end
  end

  // Monitor: collects fill beats, AR handshakes and AR stability while waiting for arready
  initial begin
    ar_count = 0; ar_unstable = 0; p_wait = 0; p_ar = '0; ar_seen = '0;
    forever begin
      logic [48:0] cur;
      @(negedge clk);
      cur = {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst};
      if (fill_valid) fills.push_back('{fill_data, int'(fill_index), fill_last, fill_err});
      if (axi.arvalid && axi.arready) begin
        ar_count++;
        ar_seen = cur;
      end
      if (p_wait && (!axi.arvalid || cur != p_ar)) ar_unstable++;
      p_wait = axi.arvalid && !axi.arready;
      p_ar   = cur;
    end
  end

  // Issue one request and wait for fill_last; lat counts cycles from request assertion to fill_last
  task automatic do_refill(input logic [31:0] addr, input int hold, output int lat);
    bit accepted = 0;
    int hold_left = hold;
    fills.delete(); ar_count = 0; ar_unstable = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; lat = 0;
    forever begin
      @(negedge clk); #1;
      lat++;
      if (fill_valid && fill_last) break;
      if (lat > 300) begin
        chk("refill_timeout", 64'(lat), 64'd0);
        break;
      end
      if (accepted && hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) req_valid = 1'b0;
      end
      if (!accepted && req_ready) begin
        accepted = 1;
        @(posedge clk); #1;
        if (hold_left > 0) req_addr = addr + 32'h40;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  // Compare one completed line against the reference: aligned AR, in-order words, error on last beat
  task automatic check_line(input string tag, input logic [31:0] addr, input bit exp_err);
    logic [31:0] base = addr & ~32'(LW * (DW / 8) - 1);
    int n;
    chk({tag, "_ar_count"}, 64'(ar_count), 64'd1);
    chk({tag, "_ar_stable"}, 64'(ar_unstable), 64'd0);
    chk({tag, "_ar_fields"}, 64'(ar_seen), 64'({4'd0, base, 8'(LW - 1), 3'd2, 2'b01}));
    chk({tag, "_fill_count"}, 64'(fills.size()), 64'(LW));
    n = (fills.size() < int'(LW)) ? fills.size() : int'(LW);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(fills[i].data), 64'(mem[(base >> 2) + 32'(i)]));
      chk($sformatf("%s_index%0d", tag, i), 64'(fills[i].idx), 64'(i));
      chk($sformatf("%s_last%0d", tag, i), 64'(fills[i].last), 64'(i == int'(LW) - 1));
    end
    if (n > 0) chk({tag, "_err"}, 64'(fills[n-1].err), 64'(exp_err));
  endtask

  initial begin
    int lat;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[32'h80 >> 2] = 32'hfe010113;
    cfg(0, 0, 0, 0, 0, -1, -1, 0);
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;

    // Reset values
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_outputs", 64'({busy, fill_valid, fill_last, fill_err, axi.arvalid, axi.rready}), 64'd0);
    chk("rst_ar_fields", 64'({axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst}), 64'd0);
    @(negedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Aligned refill, zero-wait
    do_refill(32'h80, 0, lat);
    check_line("aligned", 32'h80, 0);
    chk("aligned_word0", 64'(fills.size() > 0 ? fills[0].data : 32'h0), 64'h fe010113);
    chk("aligned_latency", 64'(lat), 64'(3 + LW));
    chk("aligned_req_ready_at_last", 64'(req_ready), 64'd1);

    // Unaligned request
    do_refill(32'h2C4, 0, lat);
    check_line("unaligned", 32'h2C4, 0);

    // Backpressure on AR and R
    cfg(5, 0, 0, 3, 1, -1, -1, 0);
    do_refill(32'h140, 0, lat);
    check_line("backpressure", 32'h140, 0);

    // Slave error on beat 1, then a clean line
    cfg(0, 0, 0, 0, 0, 1, -1, 0);
    do_refill(32'h400, 0, lat);
    check_line("slverr", 32'h400, 1);
    cfg(0, 0, 0, 0, 0, -1, -1, 0);
    do_refill(32'h404, 0, lat);
    check_line("after_err", 32'h404, 0);

    // Early rlast on beat 2, then wrong rid
    cfg(0, 0, 1, 0, 0, -1, 2, 0);
    do_refill(32'h500, 0, lat);
    check_line("early_rlast", 32'h500, 1);
    cfg(0, 0, 0, 0, 0, -1, -1, 1);
    do_refill(32'h600, 0, lat);
    check_line("bad_rid", 32'h600, 1);

    // Request held while busy must not produce a second burst
    cfg(0, 0, 0, 0, 0, -1, -1, 0);
    do_refill(32'h300, 3, lat);
    check_line("held_req", 32'h300, 0);
    repeat (4) @(negedge clk);
    chk("held_req_no_second_ar", 64'(ar_count), 64'd1);

    // Randomized lines against the reference
    for (int t = 0; t < 10; t++) begin
      int eb, rlb;
      eb  = int'($urandom_range(0, 7)); if (eb >= int'(LW)) eb = -1;
      rlb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), eb, rlb, $urandom_range(0, 5) == 0);
      a = 32'($urandom_range(0, 4095));
      do_refill(a, 0, lat);
      check_line($sformatf("rand%0d", t), a, model_err());
    end

    // Reset in the middle of DATA, right after beat 1
    cfg(0, 0, 0, 3, 3, -1, -1, 0);
    fills.delete();
    @(posedge clk); #1; req_valid = 1'b1; req_addr = 32'h100;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int c = 0; c < 50 && fills.size() < 2; c++) begin
      @(negedge clk); #1;
    end
    chk("midrst_beats_before", 64'(fills.size()), 64'd2);
    chk("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({req_ready, busy, fill_valid, fill_last, fill_err, axi.arvalid, axi.rready}), 64'd0);
    chk("midrst_fill_bus", 64'({fill_data, fill_index}), 64'd0);
    chk("midrst_ar_fields", 64'({axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst}), 64'd0);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    cfg(0, 0, 0, 0, 0, -1, -1, 0);
    do_refill(32'h200, 0, lat);
    check_line("after_midrst", 32'h200, 0);
    chk("after_midrst_latency", 64'(lat), 64'(3 + LW));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
